// File: rtl/mem_rr_arbiter_pkg.sv
// Shared defaults, payload/response types and round-robin helper for the
// memory round-robin arbiter.
package mem_arb_pkg;

   localparam int unsigned DefNumReq    = 2;
   localparam int unsigned DefAddrWidth = 64;
   localparam int unsigned DefDataWidth = 64;
   localparam int unsigned DefStrbWidth = DefDataWidth >> 3;
   localparam int unsigned DefIdxWidth  = (DefNumReq > 1) ? $clog2(DefNumReq) : 1;

   typedef struct packed {
      logic [DefAddrWidth-1:0] addr;
      logic [DefDataWidth-1:0] wdata;
      logic [DefStrbWidth-1:0] strb;
      logic                    we;
   } req_payload_t;

   typedef struct packed {
      logic                   valid;
      logic [DefIdxWidth-1:0] idx;
   } rsp_entry_t;

   // Modulo increment that wraps explicitly, so non-power-of-2 counts work.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) return 32'd0;
      return idx + 32'd1;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the arbiter.
// The slave view belongs to the arbiter; master is the requesters plus SRAM.
interface mem_rr_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned NumReq    = DefNumReq,
   parameter int unsigned AddrWidth = DefAddrWidth,
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned StrbWidth = DataWidth >> 3
);
   logic [NumReq-1:0]                req;
   logic [NumReq-1:0]                gnt;
   logic [NumReq-1:0][AddrWidth-1:0] addr;
   logic [NumReq-1:0][DataWidth-1:0] wdata;
   logic [NumReq-1:0][StrbWidth-1:0] strb;
   logic [NumReq-1:0]                we;
   logic [NumReq-1:0]                rvalid;
   logic [DataWidth-1:0]             rdata;

   logic                 mem_req;
   logic                 mem_gnt;
   logic [AddrWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_wdata;
   logic [StrbWidth-1:0] mem_strb;
   logic                 mem_we;
   logic [DataWidth-1:0] mem_rdata;

   modport slave (
      input  req, addr, wdata, strb, we, mem_gnt, mem_rdata,
      output gnt, rvalid, rdata, mem_req, mem_addr, mem_wdata, mem_strb, mem_we
   );

   modport master (
      output req, addr, wdata, strb, we, mem_gnt, mem_rdata,
      input  gnt, rvalid, rdata, mem_req, mem_addr, mem_wdata, mem_strb, mem_we
   );
endinterface

// File: rtl/mem_rr_arbiter_core.sv
// Round-robin pointer plus combinational same-cycle winner selection.
// The scan starts at the pointer and wraps modulo NumReq.
module mem_rr_arb_core
   import mem_arb_pkg::*;
#(
   parameter int unsigned NumReq   = DefNumReq,
   parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumReq-1:0]   req_i,
   input  logic                en_i,
   output logic [NumReq-1:0]   gnt_o,
   output logic [IdxWidth-1:0] winner_o,
   output logic                valid_o
);
   logic [IdxWidth-1:0] ptr_q;
   logic [IdxWidth-1:0] ptr_d;
   logic [IdxWidth-1:0] win;
   logic                found;

   always_comb begin
      int unsigned cand;
      cand  = 32'd0;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NumReq) cand = cand - NumReq;
         if (!found && req_i[IdxWidth'(cand)]) begin
            found = 1'b1;
            win   = IdxWidth'(cand);
         end
      end
      ptr_d = (found && en_i) ? IdxWidth'(rr_next(32'(win), NumReq)) : ptr_q;
   end

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
      assign gnt_o[gi] = en_i & found & (win == IdxWidth'(gi));
   end

   assign winner_o = win;
   assign valid_o  = found;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one SRAM port among NumReq requesters: round-robin grant, payload mux,
// and a fixed-latency owner pipeline that steers the response valid.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NumReq     = DefNumReq,
   parameter int unsigned AddrWidth  = DefAddrWidth,
   parameter int unsigned DataWidth  = DefDataWidth,
   parameter int unsigned StrbWidth  = DataWidth >> 3,
   parameter int unsigned MemLatency = 1
) (
   input logic              clk_i,
   input logic              rst_ni,
   mem_rr_arbiter_if.slave  bus
);
   localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
      logic [StrbWidth-1:0] strb;
      logic                 we;
   } payload_t;

   typedef struct packed {
      logic                valid;
      logic [IdxWidth-1:0] idx;
   } entry_t;

   logic [NumReq-1:0]   gnt;
   logic [IdxWidth-1:0] winner;
   logic                any_req;
   logic                hs;
   payload_t            sel;
   entry_t              rsp_q [MemLatency];

   mem_rr_arb_core #(
      .NumReq   (NumReq),
      .IdxWidth (IdxWidth)
   ) u_core (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (bus.req),
      .en_i     (bus.mem_gnt),
      .gnt_o    (gnt),
      .winner_o (winner),
      .valid_o  (any_req)
   );

   // Payload follows the winner even while the memory stalls; zero when idle.
   always_comb begin
      sel = '0;
      if (any_req) begin
         sel.addr  = bus.addr[winner];
         sel.wdata = bus.wdata[winner];
         sel.strb  = bus.strb[winner];
         sel.we    = bus.we[winner];
      end
   end

   assign hs            = |gnt;
   assign bus.gnt       = gnt;
   assign bus.mem_req   = |bus.req;
   assign bus.mem_addr  = sel.addr;
   assign bus.mem_wdata = sel.wdata;
   assign bus.mem_strb  = sel.strb;
   assign bus.mem_we    = sel.we;
   assign bus.rdata     = bus.mem_rdata;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MemLatency; i++) rsp_q[i] <= '0;
      end else begin
         rsp_q[0] <= {hs, winner};
         for (int i = 1; i < MemLatency; i++) rsp_q[i] <= rsp_q[i-1];
      end
   end

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_rvalid
      assign bus.rvalid[gi] = rsp_q[MemLatency-1].valid &
                              (rsp_q[MemLatency-1].idx == IdxWidth'(gi));
   end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a small one-cycle-latency SRAM model.
module tb_mem_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter_if #(.NumReq(2), .AddrWidth(64), .DataWidth(64), .StrbWidth(8)) bus ();

   mem_rr_arbiter #(
      .NumReq(2), .AddrWidth(64), .DataWidth(64), .StrbWidth(8), .MemLatency(1)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // SRAM model: 16 words indexed by addr[6:3], byte-strobed writes, 1-cycle reads
   logic [63:0] mem [16];
   logic [63:0] rd_q = '0;
   logic        mem_clr = 1'b0;
   logic        pl_en = 1'b0;
   logic [3:0]  pl_idx = '0;
   logic [63:0] pl_data = '0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (bus.mem_req && bus.mem_gnt) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 8; b++)
               if (bus.mem_strb[b]) mem[bus.mem_addr[6:3]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
         end else begin
            rd_q <= mem[bus.mem_addr[6:3]];
         end
      end
   end
   assign bus.mem_rdata = rd_q;

   task automatic drive_idle();
      bus.req   = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      bus.strb  = '0;
      bus.we    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_clr = 1'b1;
      bus.mem_gnt = 1'b1;
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total += 4;
         if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
         if (bus.rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b expected 00", bus.rvalid); end
         if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
         if (bus.mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      mem_clr = 1'b0;
      $display("txn reset released");
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      prev_g = 2'b00;
      bus.req = 2'b11;
      bus.addr[0] = 64'h8000_0000;
      bus.addr[1] = 64'h8000_0018;
      for (int c = 0; c < 6; c++) begin
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         total += 2;
         if (bus.gnt !== exp_g) begin bad++; $display("FAIL contention_gnt c=%0d: got %b expected %b", c, bus.gnt, exp_g); end
         if (bus.rvalid !== prev_g) begin bad++; $display("FAIL contention_rvalid c=%0d: got %b expected %b", c, bus.rvalid, prev_g); end
         $display("txn contention c=%0d gnt=%b rvalid=%b", c, bus.gnt, bus.rvalid);
         prev_g = exp_g;
         @(posedge clk); #1;
      end
      drive_idle();
      @(negedge clk);
      total++;
      if (bus.rvalid !== 2'b10) begin bad++; $display("FAIL contention_last_rvalid: got %b expected 10", bus.rvalid); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      pl_en = 1'b1; pl_idx = 4'd1; pl_data = 64'h0000_0000_DEAD_BEEF;
      @(posedge clk); #1;
      pl_en = 1'b0;
      bus.req = 2'b01;
      bus.addr[0] = 64'h8000_0008;
      bus.we = 2'b00;
      @(negedge clk);
      total += 3;
      if (bus.gnt !== 2'b01) begin bad++; $display("FAIL read_gnt: got %b expected 01", bus.gnt); end
      if (bus.mem_addr !== 64'h8000_0008) begin bad++; $display("FAIL read_mem_addr: got %h expected 80000008", bus.mem_addr); end
      if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL read_mem_we: got %b expected 0", bus.mem_we); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      total += 2;
      if (bus.rvalid !== 2'b01) begin bad++; $display("FAIL read_rvalid: got %b expected 01", bus.rvalid); end
      if (bus.rdata !== 64'h0000_0000_DEAD_BEEF) begin bad++; $display("FAIL read_rdata: got %h expected deadbeef", bus.rdata); end
      $display("txn single_read rvalid=%b rdata=%h", bus.rvalid, bus.rdata);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (bus.rvalid !== 2'b00) begin bad++; $display("FAIL read_rvalid_once: got %b expected 00", bus.rvalid); end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      bus.req = 2'b10;
      bus.addr[1]  = 64'h8000_0010;
      bus.wdata[1] = 64'h1122_3344_5566_7788;
      bus.strb[1]  = 8'h0F;
      bus.we       = 2'b10;
      @(negedge clk);
      total += 4;
      if (bus.gnt !== 2'b10) begin bad++; $display("FAIL write_gnt: got %b expected 10", bus.gnt); end
      if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL write_mem_we: got %b expected 1", bus.mem_we); end
      if (bus.mem_strb !== 8'h0F) begin bad++; $display("FAIL write_mem_strb: got %h expected 0f", bus.mem_strb); end
      if (bus.mem_wdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL write_mem_wdata: got %h expected 1122334455667788", bus.mem_wdata); end
      $display("txn write req1 addr=80000010 strb=0f");
      @(posedge clk); #1;
      drive_idle();
      bus.req = 2'b01;
      bus.addr[0] = 64'h8000_0010;
      @(negedge clk);
      total += 2;
      if (bus.gnt !== 2'b01) begin bad++; $display("FAIL wr_read_gnt: got %b expected 01", bus.gnt); end
      if (bus.rvalid !== 2'b10) begin bad++; $display("FAIL write_rvalid: got %b expected 10", bus.rvalid); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      total += 2;
      if (bus.rvalid !== 2'b01) begin bad++; $display("FAIL wr_read_rvalid: got %b expected 01", bus.rvalid); end
      if (bus.rdata !== 64'h0000_0000_5566_7788) begin bad++; $display("FAIL wr_read_rdata: got %h expected 0000000055667788", bus.rdata); end
      $display("txn read req0 addr=80000010 rdata=%h", bus.rdata);
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bus.mem_gnt = 1'b0;
      bus.req = 2'b10;
      bus.addr[1] = 64'h8000_0020;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total += 4;
         if (bus.gnt !== 2'b00) begin bad++; $display("FAIL bp_gnt c=%0d: got %b expected 00", c, bus.gnt); end
         if (bus.rvalid !== 2'b00) begin bad++; $display("FAIL bp_rvalid c=%0d: got %b expected 00", c, bus.rvalid); end
         if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL bp_mem_req c=%0d: got %b expected 1", c, bus.mem_req); end
         if (bus.mem_addr !== 64'h8000_0020) begin bad++; $display("FAIL bp_mem_addr c=%0d: got %h expected 80000020", c, bus.mem_addr); end
         $display("txn backpressure c=%0d gnt=%b", c, bus.gnt);
         @(posedge clk); #1;
      end
      // Pointer sits at 1 from the previous read; a stall must not move it.
      bus.req = 2'b11;
      @(negedge clk);
      total++;
      if (bus.gnt !== 2'b00) begin bad++; $display("FAIL bp_both_gnt: got %b expected 00", bus.gnt); end
      @(posedge clk); #1;
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      total++;
      if (bus.gnt !== 2'b10) begin bad++; $display("FAIL bp_release_gnt: got %b expected 10", bus.gnt); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      total++;
      if (bus.rvalid !== 2'b10) begin bad++; $display("FAIL bp_release_rvalid: got %b expected 10", bus.rvalid); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      bus.req = 2'b01;
      bus.addr[0] = 64'h8000_0008;
      @(negedge clk);
      total++;
      if (bus.gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt: got %b expected 01", bus.gnt); end
      @(posedge clk);
      rst_n = 1'b0;
      drive_idle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if (bus.rvalid !== 2'b00) begin bad++; $display("FAIL mid_rvalid c=%0d: got %b expected 00", c, bus.rvalid); end
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      bus.req = 2'b11;
      @(negedge clk);
      total += 2;
      if (bus.gnt !== 2'b01) begin bad++; $display("FAIL mid_ptr_gnt: got %b expected 01", bus.gnt); end
      if (bus.rvalid !== 2'b00) begin bad++; $display("FAIL mid_after_rvalid: got %b expected 00", bus.rvalid); end
      $display("txn reset_midflight gnt_after=%b", bus.gnt);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      total++;
      if (bus.rvalid !== 2'b01) begin bad++; $display("FAIL mid_post_rvalid: got %b expected 01", bus.rvalid); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.mem_gnt = 1'b1;
      drive_idle();
      test_reset();
      test_contention();
      test_single_read();
      test_write_read();
      test_backpressure();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
